// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  // Product register write select
  localparam logic W_CTRL_LOAD = 1'b0;
  localparam logic W_CTRL_EXEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Moore part of the control word (adding_ctrl is handled separately)
  typedef struct packed {
    logic w_ctrl;
    logic hold;
    logic rdy;
    logic busy;
  } mult_outs_t;

  // Control word for the state being entered; unknown encodings look like IDLE
  function automatic mult_outs_t state_outputs(input mult_state_t s);
    mult_outs_t o;
    case (s)
      IDLE:    o = '{w_ctrl: W_CTRL_EXEC, hold: 1'b1, rdy: 1'b0, busy: 1'b0};
      LOAD:    o = '{w_ctrl: W_CTRL_LOAD, hold: 1'b0, rdy: 1'b0, busy: 1'b1};
      RUN:     o = '{w_ctrl: W_CTRL_EXEC, hold: 1'b0, rdy: 1'b0, busy: 1'b1};
      DONE:    o = '{w_ctrl: W_CTRL_EXEC, hold: 1'b1, rdy: 1'b1, busy: 1'b0};
      default: o = '{w_ctrl: W_CTRL_EXEC, hold: 1'b1, rdy: 1'b0, busy: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the RUN phase; flags the final iteration.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter  int WIDTH = MULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Clear has priority so the count never passes WIDTH-1
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Sequencing FSM for the unsigned shift-add multiplier.
// Control outputs change on posedge so they are settled when the Product
// register samples them on negedge.
// Optional feature: define MULT_CTRL_PERF_EN to add the ops_done counter port.
module mult_control
  import mult_pkg::*;
#(
  parameter  int WIDTH = MULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lsb,
  output logic             w_ctrl_Product,
  output logic             adding_ctrl,
  output logic             prod_hold,
  output logic             rdy,
  output logic             busy,
  output logic [CNT_W-1:0] iter
`ifdef MULT_CTRL_PERF_EN
  ,
  output logic [31:0]      ops_done
`endif
);

  mult_state_t state_r;
  mult_outs_t  outs_r;
  logic        last_s;
  logic        cnt_inc_s;
  logic        cnt_clr_s;

  // Count only while running; restart from zero on the last iteration and
  // everywhere outside RUN so each launch starts clean
  assign cnt_inc_s = (state_r == RUN);
  assign cnt_clr_s = (state_r != RUN) || last_s;

  mult_iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .count (iter),
    .last  (last_s)
  );

  // State register plus registered control word for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      outs_r  <= state_outputs(IDLE);
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= LOAD;
            outs_r  <= state_outputs(LOAD);
          end
        end
        LOAD: begin
          state_r <= RUN;
          outs_r  <= state_outputs(RUN);
        end
        RUN: begin
          if (last_s) begin
            state_r <= DONE;
            outs_r  <= state_outputs(DONE);
          end
        end
        DONE: begin
          if (start) begin
            state_r <= LOAD;
            outs_r  <= state_outputs(LOAD);
          end
        end
        default: begin
          state_r <= IDLE;
          outs_r  <= state_outputs(IDLE);
        end
      endcase
    end
  end

`ifdef MULT_CTRL_PERF_EN
  // Completed-multiply count, bumped on every RUN->DONE transition
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done <= 32'd0;
    end else if ((state_r == RUN) && last_s) begin
      ops_done <= ops_done + 32'd1;
    end
  end
`endif

  assign w_ctrl_Product = outs_r.w_ctrl;
  assign prod_hold      = outs_r.hold;
  assign rdy            = outs_r.rdy;
  assign busy           = outs_r.busy;

  // Add decision follows the current Product LSB, only meaningful in RUN
  assign adding_ctrl = (state_r == RUN) ? lsb : 1'b0;

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control: a Product register model closes the
// loop through lsb, a scoreboard queue holds expected operand pairs, and a
// monitor compares product, per-iteration add decisions and phase lengths.
module tb_mult_control;
  import mult_pkg::*;

  localparam int W     = 32;
  localparam int CNT_W = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             lsb;
  logic             w_ctrl_Product;
  logic             adding_ctrl;
  logic             prod_hold;
  logic             rdy;
  logic             busy;
  logic [CNT_W-1:0] iter;
`ifdef MULT_CTRL_PERF_EN
  logic [31:0]      ops_done;
`endif

  mult_control #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .lsb            (lsb),
    .w_ctrl_Product (w_ctrl_Product),
    .adding_ctrl    (adding_ctrl),
    .prod_hold      (prod_hold),
    .rdy            (rdy),
    .busy           (busy),
    .iter           (iter)
`ifdef MULT_CTRL_PERF_EN
    ,
    .ops_done       (ops_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] prod   = 64'd0;
  logic [31:0] mcand  = 32'd0;
  logic [31:0] mplier = 32'd0;

  assign lsb = prod[0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Product register model: loads {0, multiplier}, otherwise add-then-shift
  always @(negedge clk) begin
    logic [32:0] sum;
    logic [64:0] wide;
    if (!prod_hold) begin
      if (w_ctrl_Product == W_CTRL_LOAD) begin
        prod <= {32'd0, mplier};
      end else begin
        sum  = {1'b0, prod[63:32]} + (adding_ctrl ? {1'b0, mcand} : 33'd0);
        wide = {sum, prod[31:0]};
        prod <= wide[64:1];
      end
    end
  end

  // Monitor: samples just after posedge and checks against the scoreboard
  int          load_cnt = 0;
  int          run_cnt  = 0;
  logic        rdy_q    = 1'b0;
  int unsigned exp_ops  = 0;
  initial begin
    op_t         op;
    logic [63:0] expect_p;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        load_cnt = 0;
        run_cnt  = 0;
        rdy_q    = 1'b0;
        exp_ops  = 0;
      end else begin
        if (busy && (w_ctrl_Product == W_CTRL_LOAD)) begin
          load_cnt++;
        end else if (busy) begin
          if (exp_q.size() == 0) begin
            chk("run_without_request", 64'd1, 64'd0);
          end else if (run_cnt < W) begin
            chk("iter", 64'(iter), 64'(run_cnt));
            chk("adding_ctrl", 64'(adding_ctrl), 64'(exp_q[0].b[run_cnt]));
          end else begin
            chk("run_overlong", 64'(run_cnt + 1), 64'(W));
          end
          run_cnt++;
        end else begin
          chk("idle_outputs", {60'd0, prod_hold, w_ctrl_Product, adding_ctrl, 1'b0 | (iter != '0)},
              64'b1100);
        end
        if (rdy && !rdy_q) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rdy", 64'd1, 64'd0);
          end else begin
            op       = exp_q.pop_front();
            expect_p = {32'd0, op.a} * {32'd0, op.b};
            chk("product", prod, expect_p);
            chk("load_cycles", 64'(load_cnt), 64'd1);
            chk("run_cycles", 64'(run_cnt), 64'(W));
          end
          load_cnt = 0;
          run_cnt  = 0;
`ifdef MULT_CTRL_PERF_EN
          exp_ops++;
          chk("ops_done", 64'(ops_done), 64'(exp_ops));
`endif
        end
        rdy_q = rdy;
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    exp_q.delete();
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Launch one multiply with a one-cycle start pulse; returns start-to-rdy latency
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    op_t op;
    mcand  = a;
    mplier = b;
    op.a   = a;
    op.b   = b;
    exp_q.push_back(op);
    start = 1'b1;
    lat   = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!rdy && lat < 200);
    if (!rdy) chk("rdy_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int   lat;
    int   n;
    op_t  op;
    rst   = 1'b1;
    start = 1'b0;

    // Reset from power-up state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {59'd0, w_ctrl_Product, prod_hold, adding_ctrl, rdy, busy}, 64'b11000);
    chk("reset_iter", 64'(iter), 64'd0);
`ifdef MULT_CTRL_PERF_EN
    chk("reset_ops_done", 64'(ops_done), 64'd0);
`endif

    // Basic 3 x 5
    run_op(32'd3, 32'd5, lat);
    chk("latency_basic", 64'(lat), 64'd34);

    // All-ones operands; result must stay presented while idle
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("latency_max", 64'(lat), 64'd34);
    repeat (10) begin
      @(negedge clk);
      chk("rdy_hold_idle", {62'd0, rdy, prod_hold}, 64'b11);
    end

    // start held high: ignored mid-run, relaunches straight out of DONE
    mcand  = 32'd7;
    mplier = $urandom;
    op.a   = mcand;
    op.b   = mplier;
    exp_q.push_back(op);
    exp_q.push_back(op);
    start = 1'b1;
    n     = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rdy && n > 1) && n < 200);
    chk("held_first_done", 64'(rdy), 64'd1);
    @(negedge clk);
    chk("b2b_relaunch", {61'd0, w_ctrl_Product, rdy, busy}, 64'b001);
    start = 1'b0;
    n     = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("held_second_done", 64'(rdy), 64'd1);

    // Reset in the middle of a run, then a clean full run
    mcand  = $urandom;
    mplier = $urandom;
    op.a   = mcand;
    op.b   = mplier;
    exp_q.push_back(op);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    while (!(busy && iter == CNT_W'(10)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_iter10", 64'(iter), 64'd10);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset", {61'd0, busy, rdy, (iter != '0)}, 64'd0);
    run_op($urandom, $urandom, lat);
    chk("latency_after_reset", 64'(lat), 64'd34);

    // Randomized operands with random idle gaps
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op($urandom, (k == 0) ? 32'd0 : $urandom, lat);
      chk("latency_rand", 64'(lat), 64'd34);
    end

    // Counter clears on reset
    do_reset(1);
`ifdef MULT_CTRL_PERF_EN
    chk("perf_after_reset", 64'(ops_done), 64'd0);
`endif
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
